uart_tx_queue: RTL and testbench

// - Byte queue and transmit sequencer that sits directly upstream of the uart core's TX side.
// - Accepts bytes from a producer over a valid/ready write port and buffers them in a FIFO.
// - Drains the FIFO one byte at a time by pulsing uart.transmit and presenting uart.tx_byte.
// - Never launches a byte while the uart reports is_transmitting.
// - Replaces the switch-driven single-byte transmit logic in the board top.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_tx_queue.sv | 119 +++++++++++
 tb/tb_uart_tx_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART TX/RX byte queues.
package uart_pkg;

  localparam int unsigned UART_BYTE_W           = 8;
  localparam int unsigned QUEUE_DEPTH_DEFAULT   = 16;
  localparam int unsigned START_TIMEOUT_DEFAULT = 8;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StLaunch    = 2'd1,
    StWaitStart = 2'd2,
    StWaitDone  = 2'd3
  } tx_queue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             push_en, pop_en;

  assign level   = LW'(wr_ptr_q - rd_ptr_q);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_en);
    rd_ptr_d = rd_ptr_q + PW'(pop_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffers producer bytes and feeds them one at a time to the UART transmitter,
// re-pulsing the start if the UART never acknowledges a launch.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = QUEUE_DEPTH_DEFAULT,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
  localparam int unsigned LW           = $clog2(DEPTH + 1),
  localparam int unsigned CW           = $clog2(START_TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   wr_ready,
  input  logic                   clr_overflow,
  output logic                   uart_transmit,
  output logic [UART_BYTE_W-1:0] uart_tx_byte,
  input  logic                   uart_is_transmitting,
  output logic [LW-1:0]          level,
  output logic                   empty,
  output logic                   overflow,
  output logic                   idle
);

  tx_queue_state_t        state_q, state_d;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   overflow_q, overflow_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_dout;

  assign fifo_push = wr_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !uart_is_transmitting) begin
          fifo_pop  = 1'b1;
          tx_byte_d = fifo_dout;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (uart_is_transmitting) begin
          state_d = StWaitDone;
        end else begin
          // No acknowledge yet: relaunch the same byte rather than drop it.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(START_TIMEOUT)) begin
            state_d = StLaunch;
          end
        end
      end
      StWaitDone: begin
        if (!uart_is_transmitting) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A write refused for fullness beats a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_valid && fifo_full) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_byte_q  <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ready      = !fifo_full;
  assign uart_transmit = (state_q == StLaunch);
  assign uart_tx_byte  = tx_byte_q;
  assign empty         = fifo_empty;
  assign overflow      = overflow_q;
  assign idle          = (state_q == StIdle) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a queue-level reference model checked every cycle,
// plus literal timing and ordering expectations.
module tb_uart_tx_queue;

  localparam int DEPTH         = 16;
  localparam int START_TIMEOUT = 8;
  localparam int LW            = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_overflow = 1'b0;
  logic          uart_is_transmitting = 1'b0;
  logic          wr_ready, uart_transmit, empty, overflow, idle;
  logic [7:0]    uart_tx_byte;
  logic [LW-1:0] level;

  uart_tx_queue #(
    .DEPTH         (DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wr_valid             (wr_valid),
    .wr_data              (wr_data),
    .wr_ready             (wr_ready),
    .clr_overflow         (clr_overflow),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .level                (level),
    .empty                (empty),
    .overflow             (overflow),
    .idle                 (idle)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // UART stand-in: 0 = acknowledge each pulse for tx_len cycles, 1 = never acknowledge,
  // 2 = hold is_transmitting high.
  int         uart_mode = 0;
  int         tx_len = 40;
  int         tx_left = 0;
  logic [7:0] pulse_bytes[$];
  int         pulse_cycs[$];

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      uart_is_transmitting = 1'b0;
      tx_left = 0;
    end else begin
      if (uart_transmit) begin
        pulse_bytes.push_back(uart_tx_byte);
        pulse_cycs.push_back(cyc);
      end
      case (uart_mode)
        2: uart_is_transmitting = 1'b1;
        1: uart_is_transmitting = 1'b0;
        default: begin
          if (uart_transmit) tx_left = tx_len;
          else if (tx_left > 0) tx_left--;
          uart_is_transmitting = (tx_left > 0);
        end
      endcase
    end
  end

  // Reference model: byte queue plus "owned byte" bookkeeping, aged in cycles since its pulse.
  logic [7:0] m_q[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_busy = 1'b0;
  bit         m_started = 1'b0;
  bit         m_pulse = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_age = 0;

  task automatic model_step();
    automatic int sz  = m_q.size();
    automatic bit acc = wr_valid && (sz < DEPTH);
    automatic bit nxt = 1'b0;
    if (!m_busy) begin
      if (sz > 0 && !uart_is_transmitting) begin
        m_byte    = m_q.pop_front();
        m_busy    = 1'b1;
        m_started = 1'b0;
        m_age     = 0;
        nxt       = 1'b1;
      end
    end else if (!m_started) begin
      if (m_age > 0 && uart_is_transmitting) begin
        m_started = 1'b1;
      end else begin
        m_age++;
        if (m_age == START_TIMEOUT + 1) begin
          m_age = 0;
          nxt   = 1'b1;
        end
      end
    end else if (!uart_is_transmitting) begin
      m_busy = 1'b0;
    end
    m_pulse = nxt;
    if (acc) m_q.push_back(wr_data);
    if (wr_valid && !(sz < DEPTH)) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_byte    = 8'h00;
      m_busy    = 1'b0;
      m_started = 1'b0;
      m_pulse   = 1'b0;
      m_ovf     = 1'b0;
      m_age     = 0;
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_all();
    if (rst_n) begin
      check("wr_ready",      32'(wr_ready),      32'(m_q.size() < DEPTH));
      check("uart_transmit", 32'(uart_transmit), 32'(m_pulse));
      check("uart_tx_byte",  32'(uart_tx_byte),  32'(m_byte));
      check("level",         32'(level),         32'(m_q.size()));
      check("empty",         32'(empty),         32'(m_q.size() == 0));
      check("overflow",      32'(overflow),      32'(m_ovf));
      check("idle",          32'(idle),          32'(!m_busy && m_q.size() == 0));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic drive_write(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check({name, "_transmit"}, 32'(uart_transmit), 32'd0);
    check({name, "_tx_byte"},  32'(uart_tx_byte), 32'h00);
    check({name, "_level"},    32'(level), 32'd0);
    check({name, "_empty"},    32'(empty), 32'd1);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
    check({name, "_idle"},     32'(idle), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (!(idle && !uart_is_transmitting) && k < limit) begin
      tick();
      k++;
    end
    check({name, "_reached_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    int t0;
    int n0;
    int np;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    tick();

    // Reset with three bytes held in the queue by a busy UART.
    uart_mode = 2;
    tick();
    for (int i = 0; i < 3; i++) drive_write(8'(8'h30 + i));
    tick();
    check("pre_reset_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("in_reset");
    repeat (3) tick();
    check_reset_vals("held_reset");
    uart_mode = 0;
    rst_n = 1'b1;
    n0 = pulse_cycs.size();
    repeat (20) tick();
    check("rst_no_pulse", 32'(pulse_cycs.size() - n0), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // Single byte into an idle queue.
    tx_len = 100;
    n0 = pulse_cycs.size();
    t0 = cyc;
    drive_write(8'h41);
    repeat (110) tick();
    np = pulse_cycs.size() - n0;
    check("single_pulse_count", 32'(np), 32'd1);
    check("single_latency", (np > 0) ? 32'(pulse_cycs[n0]) : 32'hFFFF_FFFF, 32'(t0 + 2));
    check("single_byte", (np > 0) ? 32'(pulse_bytes[n0]) : 32'hFFFF_FFFF, 32'h41);
    check("single_tx_byte_held", 32'(uart_tx_byte), 32'h41);
    check("single_idle", 32'(idle), 32'd1);

    // Burst of 17 into a 16-deep queue, then an overflowing write and the clear sequence.
    tx_len = 40;
    n0 = pulse_cycs.size();
    for (int i = 0; i < 17; i++) drive_write(8'(i));
    check("burst_level_full", 32'(level), 32'd16);
    check("burst_ready_low", 32'(wr_ready), 32'd0);
    check("burst_no_ovf_yet", 32'(overflow), 32'd0);
    drive_write(8'hEE);
    check("burst_ovf_set", 32'(overflow), 32'd1);
    check("burst_level_kept", 32'(level), 32'd16);
    wr_valid = 1'b1;
    wr_data = 8'hEF;
    clr_overflow = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("ovf_set_beats_clr", 32'(overflow), 32'd1);
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_still_full", 32'(level), 32'd16);
    wait_idle("burst", 2500);
    np = pulse_cycs.size() - n0;
    check("burst_pulse_count", 32'(np), 32'd17);
    for (int i = 0; i < np && i < 17; i++)
      check("burst_order", 32'(pulse_bytes[n0 + i]), 32'(i));

    // Busy gating: nothing launches until is_transmitting drops.
    uart_mode = 2;
    tick();
    n0 = pulse_cycs.size();
    drive_write(8'h55);
    repeat (20) tick();
    check("busy_no_pulse", 32'(pulse_cycs.size() - n0), 32'd0);
    check("busy_level", 32'(level), 32'd1);
    uart_mode = 0;
    t0 = cyc;
    repeat (5) tick();
    np = pulse_cycs.size() - n0;
    check("busy_release_pulses", 32'(np), 32'd1);
    check("busy_release_cycle", (np > 0) ? 32'(pulse_cycs[n0]) : 32'hFFFF_FFFF, 32'(t0 + 1));
    check("busy_byte", (np > 0) ? 32'(pulse_bytes[n0]) : 32'hFFFF_FFFF, 32'h55);
    wait_idle("busy", 200);

    // Launch with no acknowledge: periodic re-pulses of the same byte.
    uart_mode = 1;
    n0 = pulse_cycs.size();
    t0 = cyc;
    drive_write(8'hA5);
    repeat (40) tick();
    np = pulse_cycs.size() - n0;
    check("retry_pulse_count", 32'(np), 32'd5);
    check("retry_first", (np > 0) ? 32'(pulse_cycs[n0]) : 32'hFFFF_FFFF, 32'(t0 + 2));
    for (int k = 1; k < np && k < 5; k++) begin
      check("retry_period", 32'(pulse_cycs[n0 + k] - pulse_cycs[n0 + k - 1]), 32'd9);
      check("retry_byte", 32'(pulse_bytes[n0 + k]), 32'hA5);
    end
    check("retry_level", 32'(level), 32'd0);
    uart_mode = 0;
    wait_idle("retry", 200);
    check("final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
    $fatal(1);
  end

endmodule
